word_receiver: RTL and testbench
================================

Name: word_receiver

Overview:
Parametrised serial-to-parallel receiver; successor to the fixed 8-bit byte receiver in the I2C peripheral. It shifts one bit per qualified sample strobe into a WIDTH-bit word in either bit order. Each completed word is presented on a holding register with a valid/ready handshake, with sticky overrun detection. It sits between the I2C bit-level front end (SCL-edge strobes) and the register/command layer.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32.
MSB_FIRST, 1, 1 = first received bit lands in out[WIDTH-1] (I2C order); 0 = first bit lands in out[0].
CW, $clog2(WIDTH+1), width of bit_count; derived, not overridden.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  synchronous, active-low reset.
enable  input  1  receiver enable; low aborts and discards any partial word.
sample  input  1  single-cycle bit strobe; `in` is captured on an edge where sample=1 and enable=1.
in  input  1  serial data bit.
clear  input  1  synchronous soft clear of all state.
out  output  WIDTH  last completed word (holding register).
out_valid  output  1  out holds an unconsumed word.
out_ready  input  1  consumer accepts out when out_valid=1.
bit_count  output  CW  bits received in the current partial word, 0..WIDTH-1.
busy  output  1  bit_count != 0.
overrun  output  1  sticky; a completed word was dropped.

Behaviour:
- Reset (rst_n=0 at edge): shift reg, out, out_valid, bit_count, overrun all 0. busy is 0.
- Priority per edge: rst_n low > clear > enable low > sample.
- clear=1: same effect as reset.
- enable=0 and no clear:
  - shift reg and bit_count go to 0.
  - out, out_valid and overrun are held.
  - The handshake still operates.
- Shift on sample&enable:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], in}.
  - MSB_FIRST=0: sr <= {in, sr[WIDTH-1:1]}.
  - bit_count increments by 1.
- Completion: sample&enable while bit_count==WIDTH-1.
  - The assembled word is the shifted value including the current `in`.
  - On that same edge: bit_count <= 0, sr <= 0.
  - out_valid is high in the cycle after the edge, so latency is 1 clock from the final strobe.
- Load rule on completion:
  - out_valid=0, or out_valid=1 with out_ready=1: out <= word, out_valid <= 1.
  - out_valid=1 with out_ready=0: word is dropped, out is unchanged, overrun <= 1.
- Handshake:
  - out_valid&out_ready with no completion on the same edge: out_valid <= 0; out retains its value.
  - out_ready while out_valid=0 has no effect.
  - out and out_valid change only on accept, completion, clear or reset.
- overrun is sticky until clear or reset; reception continues normally after overrun.
- Back-to-back strobes on consecutive cycles are legal; a WIDTH-bit word can complete every WIDTH cycles.
- enable dropping mid-word discards the partial word. Reception restarts at bit 0 when enable returns.
- sample pulses while enable=0 are ignored.
- in is treated as synchronous; any synchronisation is done upstream.

Test Plan:
- Reset, then WIDTH=8, MSB_FIRST=1, strobe bits 1,0,1,0,0,1,0,1 -> out=8'hA5 and out_valid=1 one cycle after the 8th strobe; bit_count counts 1..7 then 0; busy goes high after the first strobe.
- MSB_FIRST=0, strobe bits 1,0,1,0,1,0,1,0 -> out=8'h55; repeat with WIDTH=12, first bit 1 and all other bits 0 -> out=12'h001.
- out_ready held 0, receive 8'h3C then 8'hC3 -> out stays 8'h3C and overrun=1; pulse clear -> out=0, out_valid=0, overrun=0.
- out_ready=1 on the same edge as the completion of a second word 8'h81 -> out=8'h81, out_valid stays 1, overrun stays 0; the next cycle with out_ready=1 gives out_valid=0.
- Strobe 3 bits, drop enable one cycle, then strobe 8 bits of 8'hF0 -> out=8'hF0; the 3 stale bits do not appear.
- Assert rst_n=0 after 5 bits -> bit_count=0 and out_valid=0 the next cycle. Pulse sample with enable=0 -> bit_count unchanged.

Source files
------------

// File: rtl/word_receiver.sv
// Serial-to-parallel word receiver: shifts one bit per qualified strobe into a WIDTH-bit word
// and presents completed words on a holding register with valid/ready and sticky overrun.
module word_receiver #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sample,
    input  logic             in,
    input  logic             clear,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    bit_count,
    output logic             busy,
    output logic             overrun
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] shifted;
    logic             strobe;
    logic             last_bit;
    logic             can_load;

    if (MSB_FIRST) begin : g_msb_first
        assign shifted = {sr_q[WIDTH-2:0], in};
    end else begin : g_lsb_first
        assign shifted = {in, sr_q[WIDTH-1:1]};
    end

    assign strobe   = enable & sample;
    assign last_bit = strobe && (bit_count == CW'(WIDTH - 1));
    // The holding register is free if empty or being drained on this same edge.
    assign can_load = !out_valid || out_ready;
    assign busy     = (bit_count != '0);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            sr_q      <= '0;
            bit_count <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (!enable) begin
                sr_q      <= '0;
                bit_count <= '0;
            end else if (sample) begin
                if (last_bit) begin
                    sr_q      <= '0;
                    bit_count <= '0;
                end else begin
                    sr_q      <= shifted;
                    bit_count <= bit_count + CW'(1);
                end
            end

            if (last_bit) begin
                if (can_load) begin
                    out       <= shifted;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_word_receiver.sv
// Self-checking bench for word_receiver: MSB-first 8-bit DUT checked via a word scoreboard,
// plus LSB-first 8-bit and 12-bit instances for bit-order and width coverage.
module tb_word_receiver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, enable, in, clear, out_ready;
    logic sample_a, sample_b, sample_c;

    logic [7:0]  out_a, out_b;
    logic [11:0] out_c;
    logic        out_valid_a, out_valid_b, out_valid_c;
    logic [3:0]  bit_count_a, bit_count_b, bit_count_c;
    logic        busy_a, busy_b, busy_c;
    logic        overrun_a, overrun_b, overrun_c;

    word_receiver #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample(sample_a), .in(in), .clear(clear),
        .out(out_a), .out_valid(out_valid_a), .out_ready(out_ready), .bit_count(bit_count_a),
        .busy(busy_a), .overrun(overrun_a)
    );

    word_receiver #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample(sample_b), .in(in), .clear(clear),
        .out(out_b), .out_valid(out_valid_b), .out_ready(out_ready), .bit_count(bit_count_b),
        .busy(busy_b), .overrun(overrun_b)
    );

    word_receiver #(.WIDTH(12), .MSB_FIRST(1'b0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample(sample_c), .in(in), .clear(clear),
        .out(out_c), .out_valid(out_valid_c), .out_ready(out_ready), .bit_count(bit_count_c),
        .busy(busy_c), .overrun(overrun_c)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_a(input logic b);
        sample_a = 1'b1;
        in       = b;
        tick();
        sample_a = 1'b0;
    endtask

    // Send bits from..to of w, most significant first.
    task automatic shift_a(input logic [7:0] w, input int from, input int to);
        for (int k = from; k <= to; k++) strobe_a(w[7-k]);
    endtask

    task automatic pop_check_a(input string tag);
        logic [31:0] exp;
        check_eq({tag, "_qsize"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check_eq({tag, "_out"}, {24'h0, out_a}, exp);
        end
    endtask

    initial begin
        logic [7:0]  w8;
        logic [11:0] w12;

        rst_n = 1'b0; enable = 1'b1; in = 1'b0; clear = 1'b0; out_ready = 1'b0;
        sample_a = 1'b0; sample_b = 1'b0; sample_c = 1'b0;
        tick(); tick();
        check_eq("rst_out", {24'h0, out_a}, 0);
        check_eq("rst_valid", {31'h0, out_valid_a}, 0);
        check_eq("rst_count", {28'h0, bit_count_a}, 0);
        check_eq("rst_busy", {31'h0, busy_a}, 0);
        check_eq("rst_overrun", {31'h0, overrun_a}, 0);
        rst_n = 1'b1;
        tick();

        // MSB-first 8'hA5 with per-bit counter checks.
        w8 = 8'hA5;
        exp_q.push_back({24'h0, w8});
        for (int k = 0; k < 8; k++) begin
            strobe_a(w8[7-k]);
            if (k < 7) begin
                check_eq($sformatf("a5_count%0d", k), {28'h0, bit_count_a}, k + 1);
                check_eq($sformatf("a5_busy%0d", k), {31'h0, busy_a}, 1);
                check_eq($sformatf("a5_novalid%0d", k), {31'h0, out_valid_a}, 0);
            end else begin
                check_eq("a5_count_wrap", {28'h0, bit_count_a}, 0);
                check_eq("a5_busy_end", {31'h0, busy_a}, 0);
                check_eq("a5_valid", {31'h0, out_valid_a}, 1);
                pop_check_a("a5");
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("a5_accept_valid", {31'h0, out_valid_a}, 0);
        check_eq("a5_accept_hold", {24'h0, out_a}, 32'hA5);

        // LSB-first 8-bit and 12-bit instances.
        w8 = 8'h55;
        for (int k = 0; k < 8; k++) begin
            sample_b = 1'b1; in = w8[k]; tick(); sample_b = 1'b0;
        end
        check_eq("lsb8_out", {24'h0, out_b}, 32'h55);
        check_eq("lsb8_valid", {31'h0, out_valid_b}, 1);
        w12 = 12'h001;
        for (int k = 0; k < 12; k++) begin
            sample_c = 1'b1; in = w12[k]; tick(); sample_c = 1'b0;
            if (k == 10) check_eq("w12_count11", {28'h0, bit_count_c}, 11);
        end
        check_eq("w12_out", {20'h0, out_c}, 32'h001);
        check_eq("w12_valid", {31'h0, out_valid_c}, 1);

        // Overrun: second word dropped while the first is unconsumed.
        exp_q.push_back(32'h3C);
        shift_a(8'h3C, 0, 7);
        shift_a(8'hC3, 0, 7);
        check_eq("ovr_flag", {31'h0, overrun_a}, 1);
        check_eq("ovr_valid", {31'h0, out_valid_a}, 1);
        pop_check_a("ovr");
        clear = 1'b1; tick(); clear = 1'b0;
        check_eq("clr_out", {24'h0, out_a}, 0);
        check_eq("clr_valid", {31'h0, out_valid_a}, 0);
        check_eq("clr_overrun", {31'h0, overrun_a}, 0);
        check_eq("clr_lsb8_valid", {31'h0, out_valid_b}, 0);

        // Accept on the same edge as a new completion.
        exp_q.push_back(32'h12);
        shift_a(8'h12, 0, 7);
        shift_a(8'h81, 0, 6);
        pop_check_a("pre81");
        exp_q.push_back(32'h81);
        out_ready = 1'b1;
        shift_a(8'h81, 7, 7);
        check_eq("same_edge_valid", {31'h0, out_valid_a}, 1);
        check_eq("same_edge_overrun", {31'h0, overrun_a}, 0);
        pop_check_a("w81");
        tick();
        out_ready = 1'b0;
        check_eq("w81_drain_valid", {31'h0, out_valid_a}, 0);
        check_eq("w81_drain_hold", {24'h0, out_a}, 32'h81);

        // Partial word discarded by enable drop.
        shift_a(8'hFF, 0, 2);
        check_eq("part_count", {28'h0, bit_count_a}, 3);
        enable = 1'b0; tick(); enable = 1'b1;
        check_eq("dis_count", {28'h0, bit_count_a}, 0);
        check_eq("dis_busy", {31'h0, busy_a}, 0);
        exp_q.push_back(32'hF0);
        shift_a(8'hF0, 0, 7);
        pop_check_a("f0");

        // Reset mid-word.
        shift_a(8'hFF, 0, 4);
        check_eq("pre_rst_count", {28'h0, bit_count_a}, 5);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        exp_q.delete();
        check_eq("mid_rst_count", {28'h0, bit_count_a}, 0);
        check_eq("mid_rst_valid", {31'h0, out_valid_a}, 0);

        // Strobes with enable low are ignored.
        enable = 1'b0;
        strobe_a(1'b1);
        strobe_a(1'b1);
        check_eq("ign_count", {28'h0, bit_count_a}, 0);
        check_eq("ign_valid", {31'h0, out_valid_a}, 0);
        enable = 1'b1;

        // Back-to-back words with the consumer always ready.
        out_ready = 1'b1;
        exp_q.push_back(32'h5A);
        shift_a(8'h5A, 0, 7);
        pop_check_a("b2b1");
        exp_q.push_back(32'h96);
        shift_a(8'h96, 0, 7);
        pop_check_a("b2b2");
        check_eq("b2b_valid", {31'h0, out_valid_a}, 1);
        check_eq("b2b_overrun", {31'h0, overrun_a}, 0);
        out_ready = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
